// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO map, STATUS layout and
// the default I/O window base.
package dmem_pkg;

  // Word offsets inside the 16-byte MMIO window (address bits [3:2])
  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CYCLE  = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  // STATUS register bit positions
  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 4;

  localparam logic [31:0] DEF_MMIO_BASE = 32'hFFFF_FFF0;

  // Pack the STATUS word; the count field is 5 bits wide (bits [8:4])
  function automatic logic [31:0] status_word(input logic full, input logic empty,
                                              input logic ovf, input logic [4:0] cnt);
    logic [31:0] w;
    w                           = '0;
    w[ST_FULL]                  = full;
    w[ST_EMPTY]                 = empty;
    w[ST_OVF]                   = ovf;
    w[ST_CNT_LSB+4:ST_CNT_LSB]  = cnt;
    return w;
  endfunction

endpackage

// File: rtl/dmem_responder_tx_fifo.sv
// Byte FIFO feeding the TX egress port. Head byte and valid come straight from
// registered state so the consumer's ready never reaches them combinationally.
module tx_fifo #(
  parameter int FIFO_DEPTH = 4,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [7:0]    i_din,
  input  logic          i_pop_ready,
  output logic          o_valid,
  output logic [7:0]    o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count,
  output logic          o_drop
);

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic w_pop;
  logic w_push_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(FIFO_DEPTH));
  assign o_valid   = !o_empty;
  assign o_dout    = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands
  assign w_pop     = o_valid && i_pop_ready;
  assign w_push_ok = i_push && (!o_full || w_pop);
  assign o_drop    = i_push && o_full && !w_pop;

  // Storage: cleared on reset so the head byte reads 0 while empty after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointers wrap naturally (power-of-two depth); count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// M-stage data-memory responder: word RAM with combinational read plus a
// 16-byte MMIO window (TX FIFO, STATUS with sticky overflow, cycle counter).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] MMIO_BASE   = DEF_MMIO_BASE,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   r_ram [DEPTH_WORDS];
  logic [31:0]   r_cycle;
  logic          r_ovf;

  logic          w_mmio_sel;
  logic [1:0]    w_off;
  logic [AW-1:0] w_idx;
  logic          w_push;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic          w_drop;
  logic          w_st_wr;
  logic          w_cyc_wr;
  logic          w_unused;

  // Byte-lane bits are meaningless for word-only accesses
  assign w_unused   = ^ALUOutM[1:0];

  assign w_mmio_sel = (ALUOutM[31:4] == MMIO_BASE[31:4]);
  assign w_off      = ALUOutM[3:2];
  assign w_idx      = ALUOutM[AW+1:2];
  assign w_push     = MemWriteM && w_mmio_sel && (w_off == OFF_TXDATA);
  assign w_st_wr    = MemWriteM && w_mmio_sel && (w_off == OFF_STATUS);
  assign w_cyc_wr   = MemWriteM && w_mmio_sel && (w_off == OFF_CYCLE);

  tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .i_push     (w_push),
    .i_din      (WriteDataM[7:0]),
    .i_pop_ready(tx_ready),
    .o_valid    (tx_valid),
    .o_dout     (tx_data),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count),
    .o_drop     (w_drop)
  );

  // Data RAM write port; contents survive reset on purpose
  always_ff @(posedge clk) begin
    if (MemWriteM && !w_mmio_sel) r_ram[w_idx] <= WriteDataM;
  end

  // Sticky overflow: a new drop outranks a clear in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (w_st_wr && WriteDataM[ST_OVF]) begin
      r_ovf <= 1'b0;
    end
  end

  // Free-running cycle counter; a bus load takes priority over the increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle <= '0;
    end else if (w_cyc_wr) begin
      r_cycle <= WriteDataM;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end

  // Load data mux: RAM or MMIO register, purely combinational
  always_comb begin
    ReadDataM = '0;
    if (w_mmio_sel) begin
      case (w_off)
        OFF_STATUS: ReadDataM = status_word(w_full, w_empty, r_ovf, 5'(w_count));
        OFF_CYCLE:  ReadDataM = r_cycle;
        default:    ReadDataM = '0;
      endcase
    end else begin
      ReadDataM = r_ram[w_idx];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder; TX bytes are checked against a scoreboard
// queue filled when the corresponding push is issued.
module tb_dmem_responder;

  localparam logic [31:0] A_TX  = 32'hFFFF_FFF0;
  localparam logic [31:0] A_ST  = 32'hFFFF_FFF4;
  localparam logic [31:0] A_CYC = 32'hFFFF_FFF8;
  localparam logic [31:0] A_RSV = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .MemWriteM (MemWriteM),
    .ALUOutM   (ALUOutM),
    .WriteDataM(WriteDataM),
    .ReadDataM (ReadDataM),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One bus cycle: drive after the edge, settle to the falling edge, and score
  // the byte that will be consumed at the next rising edge.
  task automatic drive(input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic rdy);
    logic [7:0] exp_b;
    @(posedge clk);
    #1;
    MemWriteM  = we;
    ALUOutM    = addr;
    WriteDataM = wd;
    tx_ready   = rdy;
    @(negedge clk);
    if (reset && tx_valid && tx_ready) begin
      check("tx_sb_avail", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_b = sb.pop_front();
        check("tx_byte", {24'd0, tx_data}, {24'd0, exp_b});
      end
    end
  endtask

  initial begin
    reset      = 1'b0;
    MemWriteM  = 1'b0;
    ALUOutM    = '0;
    WriteDataM = '0;
    tx_ready   = 1'b0;

    // Reset state
    repeat (3) drive(0, A_ST, 0, 0);
    check("rst_status", ReadDataM, 32'h2);
    check("rst_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_data", {24'd0, tx_data}, 32'd0);
    drive(0, A_CYC, 0, 0);
    check("rst_cycle", ReadDataM, 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    drive(0, A_CYC, 0, 0);
    check("cycle_first", ReadDataM, 32'd1);

    // RAM store/load, aliasing, same-cycle old value
    drive(1, 32'h10, 32'hDEAD_BEEF, 0);
    drive(0, 32'h10, 0, 0);
    check("ram_load", ReadDataM, 32'hDEAD_BEEF);
    drive(0, 32'h110, 0, 0);
    check("ram_alias", ReadDataM, 32'hDEAD_BEEF);
    drive(1, 32'h20, 32'h1111_1111, 0);
    drive(1, 32'h20, 32'h2222_2222, 0);
    check("ram_old_val", ReadDataM, 32'h1111_1111);
    drive(0, 32'h20, 0, 0);
    check("ram_new_val", ReadDataM, 32'h2222_2222);
    drive(1, A_RSV, 32'hFFFF_FFFF, 0);
    drive(0, A_RSV, 0, 0);
    check("rsvd_read", ReadDataM, 32'd0);

    // Fill past full: fifth byte dropped, OVF set
    for (int i = 0; i < 5; i++) begin
      drive(1, A_TX, 32'h41 + 32'(i), 0);
      if (i < 4) sb.push_back(8'(8'h41 + i));
    end
    drive(0, A_ST, 0, 0);
    check("full_status", ReadDataM, 32'h45);
    check("full_valid", {31'd0, tx_valid}, 32'd1);
    check("full_head", {24'd0, tx_data}, 32'h41);
    drive(0, A_TX, 0, 0);
    check("txdata_read", ReadDataM, 32'd0);
    repeat (4) drive(0, A_ST, 0, 1);
    drive(0, A_ST, 0, 0);
    check("drain_status", ReadDataM, 32'h6);
    check("drain_valid", {31'd0, tx_valid}, 32'd0);

    // OVF is sticky until written with bit2 set
    drive(1, A_ST, 32'hFFFF_FFFB, 0);
    drive(0, A_ST, 0, 0);
    check("ovf_kept", ReadDataM, 32'h6);
    drive(1, A_ST, 32'h4, 0);
    drive(0, A_ST, 0, 0);
    check("ovf_clear", ReadDataM, 32'h2);

    // Push into a full FIFO while it pops: accepted, no overflow
    for (int i = 0; i < 4; i++) begin
      drive(1, A_TX, 32'h61 + 32'(i), 0);
      sb.push_back(8'(8'h61 + i));
    end
    drive(1, A_TX, 32'h55, 1);
    sb.push_back(8'h55);
    drive(0, A_ST, 0, 0);
    check("pushpop_stat", ReadDataM, 32'h41);
    check("pushpop_head", {24'd0, tx_data}, 32'h62);
    repeat (4) drive(0, A_ST, 0, 1);
    drive(0, A_ST, 0, 0);
    check("pushpop_empty", ReadDataM, 32'h2);

    // Cycle counter load and wrap
    drive(1, A_CYC, 32'hFFFF_FFFE, 0);
    drive(0, A_CYC, 0, 0);
    check("cyc_load", ReadDataM, 32'hFFFF_FFFE);
    drive(0, A_CYC, 0, 0);
    check("cyc_inc", ReadDataM, 32'hFFFF_FFFF);
    drive(0, A_CYC, 0, 0);
    check("cyc_wrap", ReadDataM, 32'h0);

    // Asynchronous reset mid-transfer
    for (int i = 0; i < 3; i++) begin
      drive(1, A_TX, 32'h71 + 32'(i), 0);
      sb.push_back(8'(8'h71 + i));
    end
    drive(0, A_ST, 0, 0);
    check("pre_rst_stat", ReadDataM, 32'h30);
    check("pre_rst_head", {24'd0, tx_data}, 32'h71);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("arst_valid", {31'd0, tx_valid}, 32'd0);
    check("arst_data", {24'd0, tx_data}, 32'd0);
    check("arst_status", ReadDataM, 32'h2);
    sb.delete();
    ALUOutM = A_CYC;
    #1;
    check("arst_cycle", ReadDataM, 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    drive(0, 32'h10, 0, 0);
    check("ram_after_rst", ReadDataM, 32'hDEAD_BEEF);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
